// File: rtl/ysyx_23060072_imem_arb_if.sv
// Bus bundle for the instruction-ROM arbiter: the IFU/BPU request and response
// channels plus the ROM read port.
// The requester side (IFU, BPU, ROM model) uses the master modport.
// The arbiter uses the slave modport.
interface ysyx_23060072_imem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          flush_i;
    logic          fetch_req_i;
    logic [AW-1:0] fetch_addr_i;
    logic          fetch_gnt_o;
    logic          fetch_rvalid_o;
    logic [DW-1:0] fetch_rdata_o;
    logic          bpu_req_i;
    logic [AW-1:0] bpu_addr_i;
    logic          bpu_gnt_o;
    logic          bpu_rvalid_o;
    logic [DW-1:0] bpu_rdata_o;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i;

    modport master (
        output flush_i, fetch_req_i, fetch_addr_i, bpu_req_i, bpu_addr_i, mem_rdata_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        input  bpu_gnt_o, bpu_rvalid_o, bpu_rdata_o, mem_en_o, mem_addr_o
    );

    modport slave (
        input  flush_i, fetch_req_i, fetch_addr_i, bpu_req_i, bpu_addr_i, mem_rdata_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        output bpu_gnt_o, bpu_rvalid_o, bpu_rdata_o, mem_en_o, mem_addr_o
    );
endinterface

// File: rtl/ysyx_23060072_imem_arb.sv
// Instruction-ROM read-port arbiter between the IF-stage fetch and the BPU.
// Fetch wins ties unless the BPU has lost STARVE_MAX times in a row.
// The ROM answers one cycle after mem_en_o.
// A one-entry owner register routes that data back to the requester that was granted.
module ysyx_23060072_imem_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_23060072_imem_arb_if.slave   bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_BPU} owner_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    owner_e        owner_q, owner_d;
    logic [3:0]    starve_q, starve_d;
    logic [DW-1:0] frdata_q, frdata_d;
    logic [DW-1:0] brdata_q, brdata_d;
    logic          fetch_win, bpu_win;
    logic          fetch_hit, bpu_hit;

    // Owner, starvation and held-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            frdata_q <= '0;
            brdata_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            frdata_q <= frdata_d;
            brdata_q <= brdata_d;
        end
    end

    // Arbitration and next-state logic. No grants are issued while reset is held.
    always_comb begin
        fetch_win = 1'b0;
        bpu_win   = 1'b0;
        if (!rst) begin
            if (bus.fetch_req_i && bus.bpu_req_i) begin
                if (starve_q >= SMAX) bpu_win   = 1'b1;
                else                  fetch_win = 1'b1;
            end else if (bus.fetch_req_i) begin
                fetch_win = 1'b1;
            end else if (bus.bpu_req_i) begin
                bpu_win = 1'b1;
            end
        end

        owner_d = fetch_win ? OWN_FETCH : (bpu_win ? OWN_BPU : OWN_NONE);

        // Count only the cycles in which the BPU asks and loses. The count saturates at the limit.
        starve_d = '0;
        if (bus.bpu_req_i && fetch_win)
            starve_d = (starve_q >= SMAX) ? SMAX : starve_q + 4'd1;

        // A response consumed this cycle becomes the held value for later cycles.
        frdata_d = fetch_hit ? bus.mem_rdata_i : frdata_q;
        brdata_d = bpu_hit   ? bus.mem_rdata_i : brdata_q;
    end

    // Output decode. A response for a fetch granted in the previous cycle is dropped
    // while a flush is asserted, because that fetch is from the old path.
    always_comb begin
        fetch_hit = !rst && (owner_q == OWN_FETCH) && !bus.flush_i;
        bpu_hit   = !rst && (owner_q == OWN_BPU);

        bus.fetch_gnt_o    = fetch_win;
        bus.bpu_gnt_o      = bpu_win;
        bus.mem_en_o       = fetch_win | bpu_win;
        bus.mem_addr_o     = fetch_win ? bus.fetch_addr_i : (bpu_win ? bus.bpu_addr_i : '0);
        bus.fetch_rvalid_o = fetch_hit;
        bus.bpu_rvalid_o   = bpu_hit;
        bus.fetch_rdata_o  = fetch_hit ? bus.mem_rdata_i : frdata_q;
        bus.bpu_rdata_o    = bpu_hit   ? bus.mem_rdata_i : brdata_q;
    end
endmodule

// File: tb/tb_ysyx_23060072_imem_arb.sv
// Bench for the instruction-ROM arbiter.
// It runs directed scenarios followed by a random phase. A behavioural model of the
// arbitration rules and a pending-response record predict every output.
module tb_ysyx_23060072_imem_arb;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_23060072_imem_arb_if #(.AW(AW), .DW(DW)) bus();

    ysyx_23060072_imem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous ROM. The read port returns junk whenever it was not enabled.
    logic [DW-1:0] rom [256];
    always @(posedge clk)
        bus.mem_rdata_i <= bus.mem_en_o ? rom[bus.mem_addr_o[9:2]] : $urandom;

    // Reference model state.
    int            losses;     // consecutive BPU losses, capped at SMAX
    int            pend;       // 0 none, 1 fetch, 2 bpu: who the ROM is answering next cycle
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] lastf, lastb;

    int n_chk, n_pass, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, predict the outputs, check them at the negedge,
    // then advance the model across the rising edge.
    task automatic step(input bit r, input bit f, input logic [AW-1:0] fa,
                        input bit b, input logic [AW-1:0] ba, input bit fl,
                        output bit gb);
        int            win;
        bit            efv, ebv;
        logic [DW-1:0] efd, ebd;
        logic [AW-1:0] eaddr;
        rst              = r;
        bus.fetch_req_i  = f;
        bus.fetch_addr_i = fa;
        bus.bpu_req_i    = b;
        bus.bpu_addr_i   = ba;
        bus.flush_i      = fl;

        win = 0;
        if (!r) begin
            if (f && b)  win = (losses >= SMAX) ? 2 : 1;
            else if (f)  win = 1;
            else if (b)  win = 2;
        end
        eaddr = (win == 1) ? fa : ((win == 2) ? ba : '0);
        efv   = !r && (pend == 1) && !fl;
        ebv   = !r && (pend == 2);
        efd   = efv ? rom[pend_addr[9:2]] : lastf;
        ebd   = ebv ? rom[pend_addr[9:2]] : lastb;

        @(negedge clk);
        chk("fetch_gnt",    bus.fetch_gnt_o,    win == 1);
        chk("bpu_gnt",      bus.bpu_gnt_o,      win == 2);
        chk("mem_en",       bus.mem_en_o,       win != 0);
        chk("mem_addr",     bus.mem_addr_o,     eaddr);
        chk("fetch_rvalid", bus.fetch_rvalid_o, efv);
        chk("fetch_rdata",  bus.fetch_rdata_o,  efd);
        chk("bpu_rvalid",   bus.bpu_rvalid_o,   ebv);
        chk("bpu_rdata",    bus.bpu_rdata_o,    ebd);
        gb = bus.bpu_gnt_o;

        @(posedge clk);
        if (r) begin
            losses = 0;
            pend   = 0;
            lastf  = '0;
            lastb  = '0;
        end else begin
            if (efv) lastf = efd;
            if (ebv) lastb = ebd;
            losses    = (b && win == 1) ? ((losses + 1 > SMAX) ? SMAX : losses + 1) : 0;
            pend      = win;
            pend_addr = (win == 1) ? fa : ba;
        end
        #1;
    endtask

    initial begin
        bit gb;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rst = 1'b1;
        bus.flush_i = 1'b0; bus.fetch_req_i = 1'b0; bus.bpu_req_i = 1'b0;
        bus.fetch_addr_i = '0; bus.bpu_addr_i = '0;
        losses = 0; pend = 0; pend_addr = '0; lastf = '0; lastb = '0;
        n_chk = 0; n_pass = 0; n_fail = 0;
        @(posedge clk); #1;

        // Reset holds off grants even when both sides request.
        step(1, 1, 32'h8, 1, 32'h4, 0, gb);

        // Single fetch at 0x8. Its data is rom[2] one cycle later.
        step(0, 1, 32'h8, 0, 32'h0, 0, gb);
        step(0, 0, 32'h0, 0, 32'h0, 0, gb);
        chk("t1_rom2", bus.fetch_rdata_o, rom[2]);

        // Continuous contention gives the grant sequence F,F,F,F,B repeating.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h100 + 32'(i * 4), 1, 32'h200 + 32'(i * 4), 0, gb);
            chk("t2_pattern", gb, (i % 5) == 4);
        end
        step(0, 0, 32'h0, 0, 32'h0, 0, gb);

        // A flush drops the stale fetch response. The redirected fetch is delivered.
        step(0, 1, 32'h10, 0, 32'h0, 0, gb);
        step(0, 1, 32'h40, 0, 32'h0, 1, gb);
        step(0, 0, 32'h0, 0, 32'h0, 0, gb);

        // A flush never suppresses a BPU response.
        step(0, 0, 32'h0, 1, 32'h4, 0, gb);
        step(0, 0, 32'h0, 0, 32'h0, 1, gb);

        // Alternate fetch and BPU grants back to back.
        for (int i = 0; i < 8; i++)
            step(0, (i % 2) == 0, 32'h300 + 32'(i * 4), (i % 2) == 1, 32'h380 + 32'(i * 4), 0, gb);
        step(0, 0, 32'h0, 0, 32'h0, 0, gb);

        // Reset while a fetch response is in flight. Then check that the starvation count restarted.
        step(0, 1, 32'h20, 0, 32'h0, 0, gb);
        step(1, 1, 32'h24, 1, 32'h28, 0, gb);
        step(0, 0, 32'h0, 0, 32'h0, 0, gb);
        for (int i = 0; i < 5; i++) step(0, 1, 32'h30, 1, 32'h34, 0, gb);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 7) == 0, gb);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
